sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-port pixel SRAM between two burst requesters: the pixel-fetch side (read bursts) and the result-writeback side (write bursts).
- Drives the SRAM address, enables and write data, holding each access for a fixed number of cycles.
- Returns read words with a valid strobe and pulls write words with a next strobe.
- Arbitrates round-robin at burst granularity. Sits between the pixel/edge datapath controllers and the SRAM model.

Parameters:
- ADDR_BITS, 16, SRAM address width.
- DATA_BITS, 24, SRAM word width (packed RGB).
- LEN_BITS, 5, burst length field width.
- MAX_BURST, 20, largest legal burst in words.
- ACCESS_CYCLES, 4, cycles each SRAM access is held (A). Legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  read burst request.
- rd_addr  in  ADDR_BITS  read burst start address.
- rd_len  in  LEN_BITS  read burst word count.
- rd_grant  out  1  one-cycle pulse; read burst accepted.
- rd_valid  out  1  one-cycle pulse; rd_data holds the next word.
- rd_data  out  DATA_BITS  registered read word.
- rd_done  out  1  one-cycle pulse; read burst finished.
- wr_req  in  1  write burst request.
- wr_addr  in  ADDR_BITS  write burst start address.
- wr_len  in  LEN_BITS  write burst word count.
- wr_data  in  DATA_BITS  current write word, presented by the requester.
- wr_grant  out  1  one-cycle pulse; write burst accepted.
- wr_next  out  1  one-cycle pulse; wr_data consumed, present the next word.
- wr_done  out  1  one-cycle pulse; write burst finished.
- address  out  ADDR_BITS  SRAM address.
- w_data  out  DATA_BITS  SRAM write data.
- r_data  in  DATA_BITS  SRAM read data.
- read_enable  out  1  SRAM read strobe.
- write_enable  out  1  SRAM write strobe.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, RD_BURST, WR_BURST. A beat counter and a cycle counter (0..A-1) are held with the latched address and length.
- Reset (rst high, asynchronous): state IDLE; all outputs 0; last_served = WR, so read wins the first tie. A reset mid-burst abandons the burst; no done pulse, enables drop immediately.
- Arbitration in IDLE, sampled each cycle:
  - Only one request high: that side wins.
  - Both high: the side not equal to last_served wins; last_served updates at grant.
- Grant timing (winner seen in cycle T):
  - At T+1 the state enters the burst and the grant pulses for one cycle.
  - addr and len are latched at the T edge; later changes to requester inputs are ignored until done.
- Length rules:
  - len greater than MAX_BURST is clamped to MAX_BURST.
  - len 0: grant at T+1, done at T+2, no SRAM access (enables stay 0), then IDLE.
- Beat timing: beat k (0-based) occupies cycles T+1+k*A through T+k*A+A.
  - address = latched_addr + k, modulo 2^ADDR_BITS (wraps from FFFF to 0000).
  - The address is stable for all A cycles of the beat.
- Read burst:
  - read_enable = 1 through all beats.
  - r_data is sampled on the last cycle of each beat into rd_data.
  - rd_valid pulses the following cycle. For beat k that cycle is T+1+(k+1)*A, which is also the first cycle of beat k+1.
  - After the final beat, rd_valid and rd_done pulse together in the cycle the state returns to IDLE. read_enable is 0 that cycle, which is the turnaround cycle.
- Write burst:
  - w_data is loaded from wr_data at the clock edge entering each beat, so word 0 must be on wr_data during cycle T.
  - wr_next pulses on the first cycle of each beat.
  - write_enable = 1 through all beats.
  - wr_done pulses the cycle after the final beat (T+1+len*A), with write_enable 0 and the state back in IDLE.
- rd_data and w_data retain their last value when not updated.
- Next grant: the earliest next grant is T+2+len*A for nonzero len, because the done cycle is IDLE and arbitrates.
- A request held high through its own done re-arbitrates as a new burst.
- read_enable and write_enable are never high simultaneously.

Test Plan:
- Single read (A=4): rd_req at cycle 0, rd_addr=0x0100, rd_len=3.
  - rd_grant @1; address 0x0100 @1-4, 0x0101 @5-8, 0x0102 @9-12.
  - rd_valid @5, @9, @13, with rd_data equal to r_data from cycles 4, 8, 12.
  - rd_done @13; read_enable 0 @13.
- Single write: wr_addr=0x0200, wr_len=2, wr_data=0xAABBCC in cycle 0.
  - wr_grant @1; w_data=0xAABBCC @1-4; wr_next @1 and @5.
  - Second word, supplied after the first wr_next, is on w_data @5-8.
  - wr_done @9; write_enable 0 @9.
- Simultaneous requests after reset: rd_req=wr_req=1 at cycle 0, each len=1.
  - Read is granted @1, write @6. Requests held → read @11, write @16, strictly alternating.
- Length edges:
  - rd_len=0 → rd_grant @1, rd_done @2, no read_enable.
  - rd_len=31 → exactly 20 rd_valid pulses.
  - wr_addr=0xFFFF, len=2 → addresses 0xFFFF then 0x0000.
- Reset mid-burst: rst at cycle 6 of a 3-word read.
  - All outputs 0 in the same cycle; no rd_done.
  - After release, a new rd_req is granted one cycle after being sampled, at address rd_addr.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin burst arbiter for the shared single-port pixel SRAM
//
// Purpose:
//   Shares one SRAM between a read-burst requester (pixel fetch) and a
//   write-burst requester (result writeback). Each SRAM access is held for
//   ACCESS_CYCLES cycles. Arbitration is round-robin at burst granularity.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   rd_req/rd_addr/rd_len    read burst request, start address, word count
//   rd_grant/rd_done         one-cycle pulses: burst accepted / finished
//   rd_valid/rd_data         one-cycle pulse with the registered read word
//   wr_req/wr_addr/wr_len    write burst request, start address, word count
//   wr_data                  current write word from the requester
//   wr_grant/wr_done         one-cycle pulses: burst accepted / finished
//   wr_next                  one-cycle pulse: wr_data consumed, present next word
//   address/w_data/r_data    SRAM address, write data, read data
//   read_enable/write_enable SRAM strobes (never both high)
//   busy                     high whenever a burst is in progress
module sram_port_arbiter #(
  parameter int ADDR_BITS     = 16,
  parameter int DATA_BITS     = 24,
  parameter int LEN_BITS      = 5,
  parameter int MAX_BURST     = 20,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [LEN_BITS-1:0]  rd_len,
  output logic                 rd_grant,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_done,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [LEN_BITS-1:0]  wr_len,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_grant,
  output logic                 wr_next,
  output logic                 wr_done,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] w_data,
  input  logic [DATA_BITS-1:0] r_data,
  output logic                 read_enable,
  output logic                 write_enable,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  localparam logic [3:0]          LAST_CYC = 4'(ACCESS_CYCLES - 1);
  localparam logic [LEN_BITS-1:0] MAX_LEN  = LEN_BITS'(MAX_BURST);
  localparam logic [LEN_BITS-1:0] ONE_LEN  = LEN_BITS'(1);

  state_t               state_q, state_d;
  logic                 last_wr_q, last_wr_d;   // last_served: 1 = write side
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  beat_q, beat_d;
  logic [3:0]           cyc_q, cyc_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [DATA_BITS-1:0] w_data_q, w_data_d;
  logic                 rd_grant_q, rd_grant_d;
  logic                 wr_grant_q, wr_grant_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_done_q, rd_done_d;
  logic                 wr_done_q, wr_done_d;

  logic                 pick_rd;
  logic                 beat_end;
  logic                 last_beat;
  logic [LEN_BITS-1:0]  rd_len_c;
  logic [LEN_BITS-1:0]  wr_len_c;

  function automatic logic [LEN_BITS-1:0] clamp_len(input logic [LEN_BITS-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    cyc_d      = cyc_q;
    rd_data_d  = rd_data_q;
    w_data_d   = w_data_q;
    rd_grant_d = 1'b0;
    wr_grant_d = 1'b0;
    rd_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    wr_done_d  = 1'b0;

    rd_len_c  = clamp_len(rd_len);
    wr_len_c  = clamp_len(wr_len);
    // Read wins when alone, or on a tie when write was served last.
    pick_rd   = rd_req && (!wr_req || last_wr_q);
    beat_end  = (cyc_q == LAST_CYC);
    last_beat = (beat_q == (len_q - ONE_LEN));

    unique case (state_q)
      S_IDLE: begin
        if (rd_req || wr_req) begin
          beat_d = '0;
          cyc_d  = '0;
          if (pick_rd) begin
            state_d    = S_RD;
            rd_grant_d = 1'b1;
            last_wr_d  = 1'b0;
            addr_d     = rd_addr;
            len_d      = rd_len_c;
          end else begin
            state_d    = S_WR;
            wr_grant_d = 1'b1;
            last_wr_d  = 1'b1;
            addr_d     = wr_addr;
            len_d      = wr_len_c;
            // Word 0 is captured on the edge that enters beat 0.
            if (wr_len_c != '0) w_data_d = wr_data;
          end
        end
      end

      S_RD: begin
        if (len_q == '0) begin
          state_d   = S_IDLE;
          rd_done_d = 1'b1;
        end else if (beat_end) begin
          rd_data_d  = r_data;
          rd_valid_d = 1'b1;
          cyc_d      = '0;
          if (last_beat) begin
            state_d   = S_IDLE;
            rd_done_d = 1'b1;
          end else begin
            beat_d = beat_q + ONE_LEN;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end

      S_WR: begin
        if (len_q == '0) begin
          state_d   = S_IDLE;
          wr_done_d = 1'b1;
        end else if (beat_end) begin
          cyc_d = '0;
          if (last_beat) begin
            state_d   = S_IDLE;
            wr_done_d = 1'b1;
          end else begin
            beat_d   = beat_q + ONE_LEN;
            w_data_d = wr_data;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_wr_q  <= 1'b1;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      cyc_q      <= '0;
      rd_data_q  <= '0;
      w_data_q   <= '0;
      rd_grant_q <= 1'b0;
      wr_grant_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      cyc_q      <= cyc_d;
      rd_data_q  <= rd_data_d;
      w_data_q   <= w_data_d;
      rd_grant_q <= rd_grant_d;
      wr_grant_q <= wr_grant_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      wr_done_q  <= wr_done_d;
    end
  end

  // A burst state lasts exactly the beats (or the single empty cycle for
  // len 0), so the strobes follow the state and drop in the done cycle.
  assign read_enable  = (state_q == S_RD) && (len_q != '0);
  assign write_enable = (state_q == S_WR) && (len_q != '0);
  assign wr_next      = write_enable && (cyc_q == 4'd0);
  assign address      = (state_q == S_IDLE) ? '0 : addr_q + ADDR_BITS'(beat_q);
  assign busy         = (state_q != S_IDLE);
  assign rd_grant     = rd_grant_q;
  assign wr_grant     = wr_grant_q;
  assign rd_valid     = rd_valid_q;
  assign rd_done      = rd_done_q;
  assign wr_done      = wr_done_q;
  assign rd_data      = rd_data_q;
  assign w_data       = w_data_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed vector bench for sram_port_arbiter
module tb_sram_port_arbiter;

  localparam int A = 4;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [4:0]  rd_len;
  logic        rd_grant;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        rd_done;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [4:0]  wr_len;
  logic [23:0] wr_data;
  logic        wr_grant;
  logic        wr_next;
  logic        wr_done;
  logic [15:0] address;
  logic [23:0] w_data;
  logic [23:0] r_data;
  logic        read_enable;
  logic        write_enable;
  logic        busy;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter #(
    .ADDR_BITS(16), .DATA_BITS(24), .LEN_BITS(5), .MAX_BURST(20), .ACCESS_CYCLES(A)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_next(wr_next), .wr_done(wr_done),
    .address(address), .w_data(w_data), .r_data(r_data),
    .read_enable(read_enable), .write_enable(write_enable), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [4:0]  len;
    logic [23:0] wbase;
    int          exp_grant;
    int          exp_done;
    int          exp_beats;
    int          exp_en;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] rdat(input int c);
    logic [23:0] k;
    k = 24'h5A0000;
    return k ^ 24'(c * 24'h010203);
  endfunction

  function automatic logic [23:0] wdat(input logic [23:0] base, input int i);
    return base + 24'(i * 24'h010101);
  endfunction

  task automatic idle_inputs();
    rd_req  = 1'b0; rd_addr = 16'h0; rd_len = 5'd0;
    wr_req  = 1'b0; wr_addr = 16'h0; wr_len = 5'd0;
    wr_data = 24'h0; r_data = 24'h0;
  endtask

  // Leaves the caller at posedge+1 of cycle 0, reset released one cycle earlier.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int g, d, beats, en, ngrant, other, widx;
    logic [15:0] exp_addr;
    g = -1; d = -1; beats = 0; en = 0; ngrant = 0; other = 0; widx = 0;
    do_reset();
    if (v.is_wr) begin
      wr_req = 1'b1; wr_addr = v.addr; wr_len = v.len; wr_data = wdat(v.wbase, 0);
    end else begin
      rd_req = 1'b1; rd_addr = v.addr; rd_len = v.len;
    end
    r_data = rdat(0);
    for (int c = 1; c <= v.exp_done + 4; c++) begin
      @(posedge clk); #1;
      // Requester inputs change after the grant edge; the latched burst must ignore them.
      rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = 16'hDEAD; rd_len = 5'd7; wr_addr = 16'hBEEF; wr_len = 5'd7;
      wr_data = wdat(v.wbase, widx);
      r_data  = rdat(c);
      #4;
      if (read_enable && write_enable) other++;
      if (v.is_wr) begin
        if (wr_grant) begin ngrant++; if (g < 0) g = c; end
        if (rd_grant || rd_valid || rd_done || read_enable) other++;
        if (wr_next) begin beats++; widx++; end
        if (wr_done && d < 0) begin
          d = c;
          check($sformatf("v%0d_done_wen", idx), 32'(write_enable), 32'd0);
          check($sformatf("v%0d_done_busy", idx), 32'(busy), 32'd0);
        end
        if (write_enable) begin
          en++;
          exp_addr = v.addr + 16'((c - 1) / A);
          check($sformatf("v%0d_addr_c%0d", idx, c), 32'(address), 32'(exp_addr));
          check($sformatf("v%0d_wdata_c%0d", idx, c), 32'(w_data), 32'(wdat(v.wbase, (c - 1) / A)));
        end
      end else begin
        if (rd_grant) begin ngrant++; if (g < 0) g = c; end
        if (wr_grant || wr_next || wr_done || write_enable) other++;
        if (rd_valid) begin
          beats++;
          check($sformatf("v%0d_rdata_c%0d", idx, c), 32'(rd_data), 32'(rdat(c - 1)));
        end
        if (rd_done && d < 0) begin
          d = c;
          check($sformatf("v%0d_done_ren", idx), 32'(read_enable), 32'd0);
          check($sformatf("v%0d_done_busy", idx), 32'(busy), 32'd0);
          check($sformatf("v%0d_done_valid", idx), 32'(rd_valid), 32'(v.len != 5'd0));
        end
        if (read_enable) begin
          en++;
          exp_addr = v.addr + 16'((c - 1) / A);
          check($sformatf("v%0d_addr_c%0d", idx, c), 32'(address), 32'(exp_addr));
        end
      end
    end
    check($sformatf("v%0d_grant_cycle", idx), 32'(g), 32'(v.exp_grant));
    check($sformatf("v%0d_grant_count", idx), 32'(ngrant), 32'd1);
    check($sformatf("v%0d_done_cycle", idx), 32'(d), 32'(v.exp_done));
    check($sformatf("v%0d_beats", idx), 32'(beats), 32'(v.exp_beats));
    check($sformatf("v%0d_enable_cycles", idx), 32'(en), 32'(v.exp_en));
    check($sformatf("v%0d_other_side", idx), 32'(other), 32'd0);
  endtask

  initial begin
    int gcyc[4];
    logic gside[4];
    int exp_c[4];
    logic exp_s[4];
    int n;
    int dones;
    int both;

    //           is_wr addr      len    wbase       grant done beats en
    vecs[0] = '{1'b0, 16'h0100, 5'd3,  24'h000000, 1, 13, 3,  12};
    vecs[1] = '{1'b1, 16'h0200, 5'd2,  24'hAABBCC, 1, 9,  2,  8};
    vecs[2] = '{1'b0, 16'h0010, 5'd0,  24'h000000, 1, 2,  0,  0};
    vecs[3] = '{1'b0, 16'h1234, 5'd31, 24'h000000, 1, 81, 20, 80};
    vecs[4] = '{1'b1, 16'hFFFF, 5'd2,  24'h123456, 1, 9,  2,  8};
    vecs[5] = '{1'b1, 16'h0020, 5'd0,  24'h111111, 1, 2,  0,  0};
    vecs[6] = '{1'b1, 16'h4000, 5'd20, 24'h0F0F0F, 1, 81, 20, 80};
    vecs[7] = '{1'b0, 16'hFFFF, 5'd1,  24'h000000, 1, 5,  1,  4};

    // Reset state.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #4;
    check("reset_ctrl",
          32'({rd_grant, rd_valid, rd_done, wr_grant, wr_next, wr_done, read_enable, write_enable, busy}),
          32'd0);
    check("reset_address", 32'(address), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_w_data", 32'(w_data), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Simultaneous requests held high: read first after reset, then strict alternation.
    exp_c = '{1, 6, 11, 16};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    n = 0; both = 0;
    do_reset();
    rd_req = 1'b1; rd_addr = 16'h0500; rd_len = 5'd1;
    wr_req = 1'b1; wr_addr = 16'h0600; wr_len = 5'd1; wr_data = 24'h010203;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      r_data = rdat(c);
      #4;
      if (read_enable && write_enable) both++;
      if (rd_grant && n < 4) begin gcyc[n] = c; gside[n] = 1'b0; n++; end
      if (wr_grant && n < 4) begin gcyc[n] = c; gside[n] = 1'b1; n++; end
    end
    check("rr_grant_count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        check($sformatf("rr_grant%0d_cycle", k), 32'(gcyc[k]), 32'(exp_c[k]));
        check($sformatf("rr_grant%0d_side", k), 32'(gside[k]), 32'(exp_s[k]));
      end
    end
    check("rr_no_overlap", 32'(both), 32'd0);

    // Reset in the middle of a 3-word read, then a fresh read.
    dones = 0;
    do_reset();
    rd_req = 1'b1; rd_addr = 16'h0300; rd_len = 5'd3;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      rd_req = 1'b0;
      r_data = rdat(c);
      if (c == 6) rst = 1'b1;
      if (c == 7) rst = 1'b0;
      if (c == 10) begin rd_req = 1'b1; rd_addr = 16'h0444; rd_len = 5'd2; end
      #4;
      if (rd_done) dones++;
      if (c == 5) check("mid_pre_ren", 32'(read_enable), 32'd1);
      if (c == 6) begin
        check("mid_rst_ctrl",
              32'({rd_grant, rd_valid, rd_done, wr_grant, wr_next, wr_done, read_enable, write_enable, busy}),
              32'd0);
        check("mid_rst_address", 32'(address), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
      end
      if (c == 11) begin
        check("mid_new_grant", 32'(rd_grant), 32'd1);
        check("mid_new_address", 32'(address), 32'h0444);
        check("mid_new_ren", 32'(read_enable), 32'd1);
      end
    end
    check("mid_no_done", 32'(dones), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
